dot_int_seq: RTL and testbench

Sequencer and accumulator for long integer dot products on top of one combinational dot_int instance (k lanes, bit_width operands).
- A job of N beats is started with a start pulse.
- Each beat streams k-element vector pairs through dot_int under valid/ready.
- The k-lane partial products are pipelined and summed into a wide signed accumulator.
- The final sum is presented on a valid/ready result port.
- Sits between the operand-fetch logic and the MX block-scaling stage.

---
 rtl/dot_int_seq_if.sv | 39 +++
 rtl/dot_int_seq.sv | 181 ++++++++++++++++++
 tb/tb_dot_int_seq.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dot_int_seq_if.sv
// ----------------------------------------------------------------------------
// dot_int_seq_if
//   Handshake bundle for the dot_int_seq sequencer.
//   Job control : i_start, i_num_beats, o_busy
//   Operand bus : i_valid/o_ready carrying i_vec_a, i_vec_b (k lanes each)
//   Result bus  : o_valid/i_ready carrying o_acc
//   The "i_"/"o_" prefixes are relative to the sequencer (slave modport).
//   The master modport is the producer/consumer side (fetch logic, MX stage).
// ----------------------------------------------------------------------------
interface dot_int_seq_if #(
    parameter int bit_width = 8,
    parameter int k         = 4,
    parameter int max_beats = 64
);
    localparam int dp_width  = 2*bit_width + $clog2(k);
    localparam int acc_width = dp_width + $clog2(max_beats);
    localparam int nb_width  = $clog2(max_beats) + 1;

    logic                         i_start;
    logic [nb_width-1:0]          i_num_beats;
    logic                         o_busy;
    logic                         i_valid;
    logic                         o_ready;
    logic [k-1:0][bit_width-1:0]  i_vec_a;
    logic [k-1:0][bit_width-1:0]  i_vec_b;
    logic                         o_valid;
    logic                         i_ready;
    logic signed [acc_width-1:0]  o_acc;

    modport slave (
        input  i_start, i_num_beats, i_valid, i_vec_a, i_vec_b, i_ready,
        output o_busy, o_ready, o_valid, o_acc
    );

    modport master (
        output i_start, i_num_beats, i_valid, i_vec_a, i_vec_b, i_ready,
        input  o_busy, o_ready, o_valid, o_acc
    );
endinterface

// File: rtl/dot_int_seq.sv
// ----------------------------------------------------------------------------
// dot_int_seq
//   Sequencer/accumulator for long signed integer dot products. A job of
//   N beats (clamped to max_beats) streams k-lane vector pairs through one
//   combinational dot_int; each beat's partial sum is registered (stage s1)
//   and then added into a wide signed accumulator. The final sum is offered
//   on a valid/ready result port and held until it is taken.
//
//   Ports:
//     i_clk    clock, all state on rising edge
//     i_rst_n  asynchronous active-low reset
//     bus      dot_int_seq_if.slave (job control, operand and result buses)
//
//   Also contains:
//     dot_int_lane  one signed bit_width x bit_width multiplier
//     dot_int       k lanes of dot_int_lane plus a sign-extending adder
// ----------------------------------------------------------------------------

// ----------------------------------------------------------------------------
// dot_int_lane: single signed product, full 2*bit_width result.
//   a, b : raw operand bits (interpreted as two's complement)
//   prod : signed product
// ----------------------------------------------------------------------------
module dot_int_lane #(
    parameter int bit_width = 8
) (
    input  logic [bit_width-1:0]          a,
    input  logic [bit_width-1:0]          b,
    output logic signed [2*bit_width-1:0] prod
);
    // Widen before multiplying so the product is computed at full width.
    assign prod = (2*bit_width)'($signed(a)) * (2*bit_width)'($signed(b));
endmodule

// ----------------------------------------------------------------------------
// dot_int: combinational k-lane signed dot product.
//   vec_a, vec_b : k packed lanes of bit_width bits
//   dp           : signed sum of lane products, dp_width bits (cannot overflow)
// ----------------------------------------------------------------------------
module dot_int #(
    parameter int bit_width = 8,
    parameter int k         = 4,
    parameter int dp_width  = 2*bit_width + $clog2(k)
) (
    input  logic [k-1:0][bit_width-1:0] vec_a,
    input  logic [k-1:0][bit_width-1:0] vec_b,
    output logic signed [dp_width-1:0]  dp
);
    logic [k-1:0][2*bit_width-1:0] prod;

    for (genvar g = 0; g < k; g++) begin : g_lane
        dot_int_lane #(.bit_width(bit_width)) u_lane (
            .a    (vec_a[g]),
            .b    (vec_b[g]),
            .prod (prod[g])
        );
    end

    always_comb begin
        dp = '0;
        for (int i = 0; i < k; i++) begin
            dp = dp + dp_width'($signed(prod[i]));
        end
    end
endmodule

// ----------------------------------------------------------------------------
// dot_int_seq: top level.
// ----------------------------------------------------------------------------
module dot_int_seq #(
    parameter int bit_width = 8,
    parameter int k         = 4,
    parameter int max_beats = 64
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    dot_int_seq_if.slave  bus
);
    localparam int dp_width  = 2*bit_width + $clog2(k);
    localparam int acc_width = dp_width + $clog2(max_beats);
    localparam int nb_width  = $clog2(max_beats) + 1;

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    // Registered per-beat partial sum.
    typedef struct packed {
        logic                vld;
        logic                last;
        logic [dp_width-1:0] dp;
    } s1_t;

    state_t                      state;
    logic [nb_width-1:0]         beats_left;
    logic signed [acc_width-1:0] acc;
    logic                        valid_q;
    s1_t                         s1;

    logic                        rdy;
    logic                        hs;
    logic [nb_width-1:0]         num_clamped;
    logic signed [dp_width-1:0]  dp;

    dot_int #(
        .bit_width (bit_width),
        .k         (k),
        .dp_width  (dp_width)
    ) u_dot (
        .vec_a (bus.i_vec_a),
        .vec_b (bus.i_vec_b),
        .dp    (dp)
    );

    // Requests above max_beats run exactly max_beats beats.
    assign num_clamped = (bus.i_num_beats > nb_width'(max_beats)) ?
                         nb_width'(max_beats) : bus.i_num_beats;

    // Ready depends only on registered state so it never loops through
    // the producer's valid.
    assign rdy = (state == ACCUM) && (beats_left != '0);
    assign hs  = bus.i_valid && rdy;

    assign bus.o_ready = rdy;
    assign bus.o_busy  = (state != IDLE);
    assign bus.o_valid = valid_q;
    assign bus.o_acc   = acc;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= IDLE;
            beats_left <= '0;
            acc        <= '0;
            valid_q    <= 1'b0;
            s1         <= '0;
        end else begin
            // Stage s1: capture the dot product of each accepted beat.
            s1.vld <= hs;
            if (hs) begin
                s1.last    <= (beats_left == nb_width'(1));
                s1.dp      <= dp;
                beats_left <= beats_left - nb_width'(1);
            end

            case (state)
                IDLE: begin
                    if (bus.i_start) begin
                        acc        <= '0;
                        beats_left <= num_clamped;
                        if (num_clamped != '0) begin
                            state <= ACCUM;
                        end else begin
                            // Empty job: publish a zero result right away.
                            state   <= DONE;
                            valid_q <= 1'b1;
                        end
                    end
                end
                ACCUM: begin
                    if (s1.vld) begin
                        acc <= acc + acc_width'($signed(s1.dp));
                        // Last partial lands in acc on the same edge DONE is entered.
                        if (s1.last) begin
                            state   <= DONE;
                            valid_q <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    // Start is not looked at here; a new job needs an IDLE cycle.
                    if (bus.i_ready) begin
                        state   <= IDLE;
                        valid_q <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dot_int_seq.sv
// ----------------------------------------------------------------------------
// tb_dot_int_seq
//   Self-checking bench for dot_int_seq (bit_width=8, k=4, max_beats=64).
//   Expected job results come from a lane-by-lane reference model and go
//   through a queue: pushed as beats are driven, popped when the result
//   appears on the result port.
// ----------------------------------------------------------------------------
module tb_dot_int_seq;
    typedef logic [3:0][7:0] vec_t;

    logic i_clk;
    logic i_rst_n;

    dot_int_seq_if #(.bit_width(8), .k(4), .max_beats(64)) bus ();

    dot_int_seq #(.bit_width(8), .k(4), .max_beats(64)) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .bus     (bus.slave)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int     n_cmp = 0;
    int     n_bad = 0;
    longint exp_q[$];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(input int e0, input int e1, input int e2, input int e3);
        vec_t v;
        v[0] = 8'(e0); v[1] = 8'(e1); v[2] = 8'(e2); v[3] = 8'(e3);
        return v;
    endfunction

    function automatic longint dot_ref(input vec_t a, input vec_t b);
        longint s = 0;
        for (int i = 0; i < 4; i++) s += longint'($signed(a[i])) * longint'($signed(b[i]));
        return s;
    endfunction

    task automatic tick();
        @(posedge i_clk); #1;
    endtask

    task automatic do_start(input int n);
        bus.i_start     = 1'b1;
        bus.i_num_beats = 7'(n);
        tick();
        bus.i_start     = 1'b0;
    endtask

    // Present a beat and hold it until accepted; valid is left high.
    task automatic drive_beat(input vec_t a, input vec_t b, output bit to);
        bus.i_valid = 1'b1;
        bus.i_vec_a = a;
        bus.i_vec_b = b;
        to = 1'b1;
        for (int n = 0; n < 50; n++) begin
            if (bus.o_ready) begin
                tick();
                to = 1'b0;
                break;
            end
            tick();
        end
    endtask

    task automatic wait_result(output bit to);
        to = 1'b1;
        for (int n = 0; n < 200; n++) begin
            if (bus.o_valid) begin
                to = 1'b0;
                break;
            end
            tick();
        end
    endtask

    task automatic take_result();
        bus.i_ready = 1'b1;
        tick();
        bus.i_ready = 1'b0;
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        bus.i_start = 0; bus.i_num_beats = '0; bus.i_valid = 0; bus.i_ready = 0;
        bus.i_vec_a = '0; bus.i_vec_b = '0;
        tick(); tick();
        n_cmp++; if (bus.o_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", bus.o_busy); end
        n_cmp++; if (bus.o_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready: got %b want 0", bus.o_ready); end
        n_cmp++; if (bus.o_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", bus.o_valid); end
        n_cmp++; if (bus.o_acc !== '0) begin n_bad++; $display("FAIL reset_acc: got %0d want 0", bus.o_acc); end
        i_rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_beat();
        vec_t a = mk(1, 2, 3, 4), b = mk(5, 6, 7, 8);
        bit to;
        longint e;
        do_start(1);
        n_cmp++; if (bus.o_busy !== 1'b1 || bus.o_ready !== 1'b1) begin n_bad++; $display("FAIL single_accum: got busy=%b ready=%b want 1 1", bus.o_busy, bus.o_ready); end
        exp_q.push_back(dot_ref(a, b));
        drive_beat(a, b, to);           // now in cycle c+1
        bus.i_valid = 1'b0;
        n_cmp++; if (to) begin n_bad++; $display("FAIL single_hs: got timeout want handshake"); end
        n_cmp++; if (bus.o_valid !== 1'b0) begin n_bad++; $display("FAIL single_early: got o_valid=%b at c+1 want 0", bus.o_valid); end
        tick();                          // cycle c+2
        e = exp_q.pop_front();
        n_cmp++; if (bus.o_valid !== 1'b1) begin n_bad++; $display("FAIL single_lat: got o_valid=%b at c+2 want 1", bus.o_valid); end
        n_cmp++; if (longint'(bus.o_acc) !== e) begin n_bad++; $display("FAIL single_acc: got %0d want %0d", bus.o_acc, e); end
        n_cmp++; if (bus.o_busy !== 1'b1) begin n_bad++; $display("FAIL single_busy: got %b want 1", bus.o_busy); end
        take_result();
        n_cmp++; if (bus.o_valid !== 1'b0 || bus.o_busy !== 1'b0) begin n_bad++; $display("FAIL single_idle: got valid=%b busy=%b want 0 0", bus.o_valid, bus.o_busy); end
    endtask

    task automatic test_gapped();
        vec_t v = mk(-128, -128, -128, -128);
        int hs = 0;
        bit to;
        longint e;
        do_start(3);
        bus.i_vec_a = v; bus.i_vec_b = v;
        exp_q.push_back(3 * dot_ref(v, v));
        for (int c = 0; c < 40 && hs < 3; c++) begin
            bus.i_valid = (c % 2 == 0);
            if (bus.i_valid && bus.o_ready) hs++;
            tick();
        end
        n_cmp++; if (hs !== 3) begin n_bad++; $display("FAIL gapped_hs: got %0d handshakes want 3", hs); end
        bus.i_valid = 1'b1;
        #1;
        n_cmp++; if (bus.o_ready !== 1'b0) begin n_bad++; $display("FAIL gapped_extra: got o_ready=%b want 0", bus.o_ready); end
        tick();
        bus.i_valid = 1'b0;
        wait_result(to);
        e = exp_q.pop_front();
        n_cmp++; if (to || longint'(bus.o_acc) !== e) begin n_bad++; $display("FAIL gapped_acc: got %0d (to=%b) want %0d", bus.o_acc, to, e); end
        take_result();
    endtask

    task automatic test_full_and_mixed();
        vec_t v = mk(-128, -128, -128, -128);
        vec_t a = mk(127, -128, 1, -1), b = mk(-128, 127, -1, 1);
        int n_to = 0;
        bit to;
        longint s = 0, e;
        do_start(64);
        for (int i = 0; i < 64; i++) begin
            drive_beat(v, v, to);
            if (to) n_to++;
            s += dot_ref(v, v);
        end
        bus.i_valid = 1'b0;
        exp_q.push_back(s);
        wait_result(to);
        e = exp_q.pop_front();
        n_cmp++; if (n_to != 0 || to || longint'(bus.o_acc) !== e) begin n_bad++; $display("FAIL full_acc: got %0d (to=%0d/%b) want %0d", bus.o_acc, n_to, to, e); end
        take_result();

        s = 0;
        do_start(5);
        for (int i = 0; i < 5; i++) begin
            drive_beat(a, b, to);
            if (to) n_to++;
            s += dot_ref(a, b);
        end
        bus.i_valid = 1'b0;
        exp_q.push_back(s);
        wait_result(to);
        e = exp_q.pop_front();
        n_cmp++; if (n_to != 0 || to || longint'(bus.o_acc) !== e) begin n_bad++; $display("FAIL mixed_acc: got %0d (to=%0d/%b) want %0d", bus.o_acc, n_to, to, e); end
        take_result();
    endtask

    task automatic test_zero_and_clamp();
        vec_t v = mk(1, 1, 1, 1);
        int n_to = 0;
        bit to;
        longint s = 0, e;
        exp_q.push_back(0);
        do_start(0);
        e = exp_q.pop_front();
        n_cmp++; if (bus.o_valid !== 1'b1 || longint'(bus.o_acc) !== e) begin n_bad++; $display("FAIL zero_res: got valid=%b acc=%0d want 1 %0d", bus.o_valid, bus.o_acc, e); end
        n_cmp++; if (bus.o_ready !== 1'b0) begin n_bad++; $display("FAIL zero_ready: got %b want 0", bus.o_ready); end
        take_result();

        do_start(100);
        for (int i = 0; i < 64; i++) begin
            drive_beat(v, v, to);
            if (to) n_to++;
            s += dot_ref(v, v);
        end
        n_cmp++; if (n_to != 0) begin n_bad++; $display("FAIL clamp_hs: got %0d timeouts want 0", n_to); end
        n_cmp++; if (bus.o_ready !== 1'b0) begin n_bad++; $display("FAIL clamp_ready: got o_ready=%b after 64 beats want 0", bus.o_ready); end
        bus.i_valid = 1'b0;
        exp_q.push_back(s);
        wait_result(to);
        e = exp_q.pop_front();
        n_cmp++; if (to || longint'(bus.o_acc) !== e) begin n_bad++; $display("FAIL clamp_acc: got %0d (to=%b) want %0d", bus.o_acc, to, e); end
        take_result();
    endtask

    task automatic test_backpressure();
        vec_t a = mk(3, -4, 5, -6), b = mk(7, 8, -9, 10), t = mk(2, 2, 2, 2);
        int n_bp = 0;
        bit to;
        longint e;
        do_start(2);
        drive_beat(a, b, to);
        drive_beat(a, b, to);
        bus.i_valid = 1'b0;
        exp_q.push_back(2 * dot_ref(a, b));
        wait_result(to);
        e = exp_q.pop_front();
        for (int c = 0; c < 5; c++) begin
            bus.i_start = 1'b1; bus.i_num_beats = 7'd1;
            tick();
            if (longint'(bus.o_acc) !== e || bus.o_valid !== 1'b1 || bus.o_ready !== 1'b0 || bus.o_busy !== 1'b1) n_bp++;
        end
        n_cmp++; if (to || n_bp != 0) begin n_bad++; $display("FAIL bp_hold: got %0d bad cycles acc=%0d (to=%b) want 0 bad acc=%0d", n_bp, bus.o_acc, to, e); end
        bus.i_ready = 1'b1;             // start still high through handshake
        tick();
        bus.i_ready = 1'b0;
        n_cmp++; if (bus.o_busy !== 1'b0 || bus.o_valid !== 1'b0) begin n_bad++; $display("FAIL bp_release: got busy=%b valid=%b want 0 0", bus.o_busy, bus.o_valid); end
        tick();
        bus.i_start = 1'b0;
        n_cmp++; if (bus.o_busy !== 1'b1 || bus.o_ready !== 1'b1) begin n_bad++; $display("FAIL bp_restart: got busy=%b ready=%b want 1 1", bus.o_busy, bus.o_ready); end
        exp_q.push_back(dot_ref(t, t));
        drive_beat(t, t, to);
        bus.i_valid = 1'b0;
        wait_result(to);
        e = exp_q.pop_front();
        n_cmp++; if (to || longint'(bus.o_acc) !== e) begin n_bad++; $display("FAIL bp_next: got %0d (to=%b) want %0d", bus.o_acc, to, e); end
        take_result();
    endtask

    task automatic test_reset_midjob();
        vec_t v = mk(9, 9, 9, 9), o = mk(1, 1, 1, 1);
        bit to;
        longint e;
        do_start(4);
        drive_beat(v, v, to);
        drive_beat(v, v, to);
        bus.i_valid = 1'b0;
        tick(); tick();
        #3 i_rst_n = 1'b0;
        #1;
        n_cmp++; if (bus.o_busy !== 0 || bus.o_ready !== 0 || bus.o_valid !== 0 || bus.o_acc !== '0) begin
            n_bad++; $display("FAIL midrst_out: got busy=%b ready=%b valid=%b acc=%0d want all 0", bus.o_busy, bus.o_ready, bus.o_valid, bus.o_acc);
        end
        tick();
        i_rst_n = 1'b1;
        tick();
        do_start(1);
        exp_q.push_back(dot_ref(o, o));
        drive_beat(o, o, to);
        bus.i_valid = 1'b0;
        wait_result(to);
        e = exp_q.pop_front();
        n_cmp++; if (to || longint'(bus.o_acc) !== e) begin n_bad++; $display("FAIL midrst_next: got %0d (to=%b) want %0d", bus.o_acc, to, e); end
        take_result();
    endtask

    initial begin
        test_reset();
        test_single_beat();
        test_gapped();
        test_full_and_mixed();
        test_zero_and_clamp();
        test_backpressure();
        test_reset_midjob();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
